// File: rtl/axi_lite_arbiter.sv
// rtl/axi_lite_arbiter.sv - two-master (IFU/LSU) AXI-Lite read arbiter onto one memory read port
// Optional macro ARB_LSU_PRIO_EN: fixed LSU priority on simultaneous requests; default is round-robin.
module axi_lite_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] ifu_araddr,
    input  logic              ifu_arvalid,
    output logic              ifu_arready,
    output logic [ADDR_W-1:0] ifu_rdata,
    output logic [1:0]        ifu_rresp,
    output logic              ifu_rvalid,
    input  logic              ifu_rready,
    input  logic [ADDR_W-1:0] lsu_araddr,
    input  logic              lsu_arvalid,
    output logic              lsu_arready,
    output logic [ADDR_W-1:0] lsu_rdata,
    output logic [1:0]        lsu_rresp,
    output logic              lsu_rvalid,
    input  logic              lsu_rready,
    output logic [ADDR_W-1:0] mem_araddr,
    output logic              mem_arvalid,
    input  logic              mem_arready,
    input  logic [ADDR_W-1:0] mem_rdata,
    input  logic [1:0]        mem_rresp,
    input  logic              mem_rvalid,
    output logic              mem_rready,
    output logic [1:0]        grant
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    state_t state_q, state_d;
    logic   owner_q, owner_d;
    logic   last_q, last_d;
    logic   pick;

    always_comb begin
`ifdef ARB_LSU_PRIO_EN
        pick = lsu_arvalid ? OWN_LSU : OWN_IFU;
`else
        // On a tie, serve whoever was not served last.
        if (ifu_arvalid && lsu_arvalid) begin
            pick = ~last_q;
        end else begin
            pick = lsu_arvalid ? OWN_LSU : OWN_IFU;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= OWN_IFU;
            last_q  <= OWN_LSU;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        grant       = 2'b00;
        mem_araddr  = '0;
        mem_arvalid = 1'b0;
        mem_rready  = 1'b0;
        ifu_arready = 1'b0;
        ifu_rdata   = '0;
        ifu_rresp   = 2'b00;
        ifu_rvalid  = 1'b0;
        lsu_arready = 1'b0;
        lsu_rdata   = '0;
        lsu_rresp   = 2'b00;
        lsu_rvalid  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ifu_arvalid || lsu_arvalid) begin
                    owner_d = pick;
                    state_d = ADDR;
                end
            end
            ADDR: begin
                grant       = owner_q ? 2'b10 : 2'b01;
                mem_araddr  = owner_q ? lsu_araddr : ifu_araddr;
                mem_arvalid = owner_q ? lsu_arvalid : ifu_arvalid;
                if (owner_q) begin
                    lsu_arready = mem_arready;
                end else begin
                    ifu_arready = mem_arready;
                end
                if (mem_arvalid && mem_arready) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                grant = owner_q ? 2'b10 : 2'b01;
                // Read data is passed straight through to the owner only.
                if (owner_q) begin
                    lsu_rdata  = mem_rdata;
                    lsu_rresp  = mem_rresp;
                    lsu_rvalid = mem_rvalid;
                    mem_rready = lsu_rready;
                end else begin
                    ifu_rdata  = mem_rdata;
                    ifu_rresp  = mem_rresp;
                    ifu_rvalid = mem_rvalid;
                    mem_rready = ifu_rready;
                end
                if (mem_rvalid && mem_rready) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_axi_lite_arbiter.sv
// tb/tb_axi_lite_arbiter.sv - randomized scoreboard bench for axi_lite_arbiter
module tb_axi_lite_arbiter;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0] ifu_araddr, lsu_araddr, mem_araddr;
    logic [W-1:0] ifu_rdata, lsu_rdata;
    logic [1:0]   ifu_rresp, lsu_rresp, grant;
    logic         ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready;
    logic         lsu_arvalid, lsu_arready, lsu_rvalid, lsu_rready;
    logic         mem_arvalid, mem_rready;
    logic         mem_arready = 1'b0;
    logic [W-1:0] mem_rdata = '0;
    logic [1:0]   mem_rresp = 2'b00;
    logic         mem_rvalid = 1'b0;

    logic [1:0]   d_arvalid = 2'b00;
    logic [1:0]   d_rready = 2'b00;
    logic [W-1:0] d_araddr [2];

    assign ifu_arvalid = d_arvalid[0];
    assign lsu_arvalid = d_arvalid[1];
    assign ifu_rready  = d_rready[0];
    assign lsu_rready  = d_rready[1];
    assign ifu_araddr  = d_araddr[0];
    assign lsu_araddr  = d_araddr[1];

    axi_lite_arbiter #(.ADDR_W(W)) dut (
        .clk(clk), .rst(rst),
        .ifu_araddr(ifu_araddr), .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready),
        .ifu_rdata(ifu_rdata), .ifu_rresp(ifu_rresp), .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready),
        .lsu_araddr(lsu_araddr), .lsu_arvalid(lsu_arvalid), .lsu_arready(lsu_arready),
        .lsu_rdata(lsu_rdata), .lsu_rresp(lsu_rresp), .lsu_rvalid(lsu_rvalid), .lsu_rready(lsu_rready),
        .mem_araddr(mem_araddr), .mem_arvalid(mem_arvalid), .mem_arready(mem_arready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp), .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .grant(grant)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory content: {rresp, rdata} derived from the address.
    function automatic logic [33:0] mem_fn(input logic [31:0] a);
        return {a[5:4], a ^ 32'h5A5A_C3C3};
    endfunction

    typedef struct {
        logic [1:0] g;
        int         due;
    } gexp_t;

    gexp_t        gq[$];
    logic [33:0]  exp_rsp0[$];
    logic [33:0]  exp_rsp1[$];
    int           cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stimulus state
    logic [1:0]   ar_pend = 2'b00;
    logic [1:0]   r_wait = 2'b00;
    logic [W-1:0] addr [2];
    int           issued [2];
    int           n_done [2];
    int           req_pct = 0, rready_pct = 100, arready_pct = 100, max_lat = 2;
    logic         issue_en = 1'b1;
    logic         mem_busy = 1'b0;
    int           mem_lat = 0;
    logic [33:0]  mem_rsp = '0;
    // Reference arbiter: phase 0 idle, 1 address, 2 data; owner 0 IFU, 1 LSU
    int           m_ph = 0, m_owner = 0, m_last = 1;
    logic [1:0]   cur = 2'b00;

    task automatic step();
        logic [1:0]   av, rr, ard, rvd, nx_rready;
        logic         nx_arready, nx_rvalid;
        logic [W-1:0] nx_rdata;
        logic [1:0]   nx_rresp;
        gexp_t        e;
        @(negedge clk);
        av  = {lsu_arvalid, ifu_arvalid};
        rr  = {lsu_rready, ifu_rready};
        ard = {lsu_arready, ifu_arready};
        rvd = {lsu_rvalid, ifu_rvalid};
        case (m_ph)
            0: if (av != 2'b00) begin
`ifdef ARB_LSU_PRIO_EN
                m_owner = av[1] ? 1 : 0;
`else
                m_owner = (av == 2'b11) ? 1 - m_last : (av[1] ? 1 : 0);
`endif
                e.g   = (m_owner == 1) ? 2'b10 : 2'b01;
                e.due = cyc + 1;
                gq.push_back(e);
                m_ph = 1;
            end
            1: if (av[m_owner] && mem_arready) m_ph = 2;
            2: if (mem_rvalid && rr[m_owner]) begin
                m_ph   = 0;
                m_last = m_owner;
            end
            default: m_ph = 0;
        endcase
        if (mem_arvalid && mem_arready) begin
            mem_busy = 1'b1;
            mem_rsp  = mem_fn(mem_araddr);
            mem_lat  = $urandom_range(0, max_lat);
        end
        if (mem_rvalid && mem_rready) mem_busy = 1'b0;
        nx_rvalid = 1'b0;
        nx_rdata  = $urandom;
        nx_rresp  = 2'($urandom);
        if (mem_busy) begin
            if (mem_lat == 0) begin
                nx_rvalid = 1'b1;
                {nx_rresp, nx_rdata} = mem_rsp;
            end else begin
                mem_lat--;
            end
        end
        nx_arready = ($urandom_range(0, 99) < arready_pct);
        for (int i = 0; i < 2; i++) begin
            if (ar_pend[i] && ard[i]) begin
                ar_pend[i] = 1'b0;
                r_wait[i]  = 1'b1;
            end else if (r_wait[i] && rvd[i] && rr[i]) begin
                r_wait[i] = 1'b0;
            end
            if (!ar_pend[i] && !r_wait[i] && issue_en && $urandom_range(0, 99) < req_pct) begin
                ar_pend[i] = 1'b1;
                addr[i]    = $urandom;
                if (i == 0) exp_rsp0.push_back(mem_fn(addr[i]));
                else        exp_rsp1.push_back(mem_fn(addr[i]));
                issued[i]++;
            end
            nx_rready[i] = ($urandom_range(0, 99) < rready_pct);
        end
        @(posedge clk);
        #1;
        d_arvalid   = ar_pend;
        d_rready    = nx_rready;
        for (int i = 0; i < 2; i++) d_araddr[i] = ar_pend[i] ? addr[i] : $urandom;
        mem_arready = nx_arready;
        mem_rvalid  = nx_rvalid;
        mem_rdata   = nx_rdata;
        mem_rresp   = nx_rresp;
    endtask

    // Monitor: pops expectations whenever the DUT presents a grant or a read response.
    always @(negedge clk) begin
        if (rst) begin
            if (gq.size() != 0 && gq[0].due == cyc) begin
                check("grant_order", grant, gq[0].g);
                check("mem_arvalid_latency", mem_arvalid, 1'b1);
                cur = gq[0].g;
                gq.pop_front();
            end else if (cur != 2'b00) begin
                if (grant == 2'b00) cur = 2'b00;
                else check("grant_hold", grant, cur);
            end else begin
                check("grant_idle", grant, 2'b00);
            end
            check("ifu_nonowner_quiet", (ifu_arready || ifu_rvalid) && (cur != 2'b01), 1'b0);
            check("lsu_nonowner_quiet", (lsu_arready || lsu_rvalid) && (cur != 2'b10), 1'b0);
            if (cur == 2'b00) check("mem_quiet_idle", mem_arvalid || mem_rready, 1'b0);
            if (mem_arvalid) check("mem_araddr_route", mem_araddr, (cur == 2'b10) ? lsu_araddr : ifu_araddr);
            if (ifu_rvalid && ifu_rready) begin
                if (exp_rsp0.size() == 0) check("ifu_r_unexpected", 1'b1, 1'b0);
                else check("ifu_rresp_rdata", {ifu_rresp, ifu_rdata}, exp_rsp0.pop_front());
                n_done[0]++;
            end
            if (lsu_rvalid && lsu_rready) begin
                if (exp_rsp1.size() == 0) check("lsu_r_unexpected", 1'b1, 1'b0);
                else check("lsu_rresp_rdata", {lsu_rresp, lsu_rdata}, exp_rsp1.pop_front());
                n_done[1]++;
            end
        end
    end

    task automatic drain();
        int k;
        issue_en = 1'b0;
        k = 0;
        while ((ar_pend != 2'b00 || r_wait != 2'b00 || m_ph != 0) && k < 500) begin
            step();
            k++;
        end
        check("drain_idle", {ar_pend, r_wait, 30'(m_ph)}, 0);
        check("drain_grant_queue", gq.size(), 0);
        check("drain_ifu_count", n_done[0], issued[0]);
        check("drain_lsu_count", n_done[1], issued[1]);
        issue_en = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"}, grant, 2'b00);
        check({tag, "_handshakes"},
              {ifu_arready, ifu_rvalid, lsu_arready, lsu_rvalid, mem_arvalid, mem_rready}, 6'b0);
        check({tag, "_mem_araddr_ifu_rdata"}, {mem_araddr, ifu_rdata}, 64'h0);
        check({tag, "_lsu_rdata"}, lsu_rdata, 32'h0);
    endtask

    initial begin
        int k;
        for (int i = 0; i < 2; i++) begin
            d_araddr[i] = '0;
            addr[i]     = '0;
            issued[i]   = 0;
            n_done[i]   = 0;
        end
        #1;
        check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Both requesters always busy: tie-break order visible in consecutive grants.
        req_pct = 100; rready_pct = 100; arready_pct = 100; max_lat = 2;
        repeat (40) step();
        drain();

        // Random traffic with stalls on every channel.
        req_pct = 45; rready_pct = 60; arready_pct = 70; max_lat = 5;
        repeat (400) step();
        drain();

        // Asynchronous reset while a read is in its data phase.
        req_pct = 80; max_lat = 5; rready_pct = 30;
        k = 0;
        while (m_ph != 2 && k < 300) begin
            step();
            k++;
        end
        check("reached_data_phase", m_ph, 2);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        d_arvalid = 2'b00; d_rready = 2'b00;
        mem_arready = 1'b0; mem_rvalid = 1'b0;
        ar_pend = 2'b00; r_wait = 2'b00; mem_busy = 1'b0;
        m_ph = 0; m_last = 1; cur = 2'b00;
        gq.delete(); exp_rsp0.delete(); exp_rsp1.delete();
        for (int i = 0; i < 2; i++) issued[i] = n_done[i];
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;

        // Same-cycle requests right after reset, then random traffic.
        req_pct = 100; rready_pct = 100; arready_pct = 100; max_lat = 1;
        repeat (20) step();
        req_pct = 50; rready_pct = 70; arready_pct = 60; max_lat = 5;
        repeat (200) step();
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end
endmodule

// File: doc/axi_lite_arbiter.md
AXI_LITE_ARBITER -- requirements
Module: axi_lite_arbiter

Interface
REQ-001 Parameter: ADDR_W, 32, address and data width of all read channels.
REQ-002 clk  input  1  single clock, all state rising-edge.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset).
REQ-004 ifu_araddr  input  32  IFU read address.
REQ-005 ifu_arvalid  input  1  IFU read-address valid.
REQ-006 ifu_arready  output  1  IFU read-address accepted.
REQ-007 ifu_rdata  output  32  read data to IFU.
REQ-008 ifu_rresp  output  2  read response to IFU.
REQ-009 ifu_rvalid  output  1  read data valid to IFU.
REQ-010 ifu_rready  input  1  IFU ready for read data.
REQ-011 lsu_araddr  input  32  LSU read address.
REQ-012 lsu_arvalid  input  1  LSU read-address valid.
REQ-013 lsu_arready  output  1  LSU read-address accepted.
REQ-014 lsu_rdata  output  32  read data to LSU.
REQ-015 lsu_rresp  output  2  read response to LSU.
REQ-016 lsu_rvalid  output  1  read data valid to LSU.
REQ-017 lsu_rready  input  1  LSU ready for read data.
REQ-018 mem_araddr  output  32  shared memory read address.
REQ-019 mem_arvalid  output  1  shared memory read-address valid.
REQ-020 mem_arready  input  1  memory accepted address.
REQ-021 mem_rdata  input  32  memory read data.
REQ-022 mem_rresp  input  2  memory read response.
REQ-023 mem_rvalid  input  1  memory read data valid.
REQ-024 mem_rready  output  1  arbiter ready for memory data.
REQ-025 grant  output  2  current owner: 00 none, 01 IFU, 10 LSU.

Function
REQ-026 FSM states IDLE, ADDR, DATA; owner and last_served held in registers; exactly one outstanding read at a time.
REQ-027 IDLE: if any arvalid high, register owner per arbitration policy, go ADDR next cycle; else stay IDLE, grant=00.
REQ-028 ADDR: mem_araddr/mem_arvalid = owner's araddr/arvalid; owner arready = mem_arready; on mem_arvalid&mem_arready go DATA.
REQ-029 DATA: owner rdata/rresp/rvalid = mem_rdata/mem_rresp/mem_rvalid; mem_rready = owner rready; on mem_rvalid&mem_rready go IDLE, last_served = owner.
REQ-030 Non-owner arready and rvalid SHALL be 0 in every state; mem_arvalid=0 outside ADDR; mem_rready=0 outside DATA.
REQ-031 Latency: arvalid first seen in IDLE cycle N -> mem_arvalid high cycle N+1; back-to-back requests lose one IDLE cycle between transactions.
REQ-032 Ownership held from grant to R handshake even if owner deasserts arvalid; arbiter never re-arbitrates mid-transaction.
REQ-033 A requester arriving during ADDR/DATA waits; it is served in next IDLE evaluation.
REQ-034 Data path is combinational pass-through; no buffering of rdata.

Reset
REQ-035 rst low: state=IDLE, grant=00, last_served=LSU, all valid/ready outputs 0, immediately (asynchronously); in-flight transaction abandoned, memory reset together.
REQ-036 First IDLE evaluation after reset release occurs on first rising clk edge with rst high.

Configuration
REQ-037 ARB_LSU_PRIO_EN defined: simultaneous requests in IDLE always grant LSU (fixed priority).
REQ-038 ARB_LSU_PRIO_EN undefined: simultaneous requests grant the requester not equal to last_served (round-robin); single requester always granted.

Verification
REQ-039 Reset release, IFU arvalid araddr=0x80000000, mem returns 0x00100073 after 2 cycles -> ifu_rdata=0x00100073, grant=01, lsu_rvalid never high.
REQ-040 IFU and LSU arvalid same cycle after reset, macro undefined -> IFU served first, then LSU; macro defined -> LSU first.
REQ-041 Both continuously requesting, 4 transactions, macro undefined -> grant sequence 01,10,01,10.
REQ-042 LSU arvalid during IFU DATA phase with mem_rvalid stalled 5 cycles -> lsu_arready stays 0 until IFU R handshake, then LSU granted.
REQ-043 rst asserted in DATA state -> all outputs 0 same cycle, grant=00, next request after release served normally.
